seq_divider: RTL and testbench

SEQ_DIVIDER -- requirements
Module: seq_divider

---
 rtl/seq_divider_pkg.sv | 13 +
 rtl/seq_divider_div_step.sv | 24 ++
 rtl/seq_divider.sv | 140 ++++++++++++++
 tb/tb_seq_divider.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/seq_divider_pkg.sv
// Shared types and defaults for the sequential restoring divider.
// Optional signed support is enabled by defining SEQ_DIVIDER_SIGNED_EN.
package seq_divider_pkg;

  localparam int DEF_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/seq_divider_div_step.sv
// One restoring division step: compare the shifted partial remainder with the
// divisor, subtract when it fits, and emit the resulting quotient bit.
module div_step
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH:0]   rem_i,
  input  logic [WIDTH-1:0] div_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             qbit_o
);

  logic [WIDTH-1:0] diff;

  // When the subtraction is taken the true difference is below the divisor,
  // so the low WIDTH bits of the wrapped difference are exact.
  always_comb begin
    diff   = rem_i[WIDTH-1:0] - div_i;
    qbit_o = (rem_i >= {1'b0, div_i});
    rem_o  = qbit_o ? diff : rem_i[WIDTH-1:0];
  end

endmodule

// File: rtl/seq_divider.sv
// Sequential restoring divider, one quotient bit per cycle, fixed latency.
// Define SEQ_DIVIDER_SIGNED_EN to honour signed_i (truncating signed division).
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             start_i,
  input  logic             signed_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o,
  output logic             div_zero_o
);

  localparam int               CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q, done_q, dz_q;
  logic [WIDTH-1:0] quo_q, rem_q;
  logic [WIDTH-1:0] acc_q, prem_q, dvs_q;
  logic [WIDTH-1:0] a_mag, b_mag, q_raw, step_rem, quo_d, rem_d;
  logic             step_qbit;
  logic             accept;

  assign accept = (state_q == ST_IDLE) && start_i;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i  ({prem_q, acc_q[WIDTH-1]}),
    .div_i  (dvs_q),
    .rem_o  (step_rem),
    .qbit_o (step_qbit)
  );

  assign q_raw = {acc_q[WIDTH-2:0], step_qbit};

`ifdef SEQ_DIVIDER_SIGNED_EN
  logic a_neg, b_neg, qneg_q, rneg_q;

  // Divide magnitudes, then restore signs; most-negative / -1 wraps back to
  // the dividend naturally.
  always_comb begin
    a_neg = signed_i & dividend_i[WIDTH-1];
    b_neg = signed_i & divisor_i[WIDTH-1];
    a_mag = a_neg ? -dividend_i : dividend_i;
    b_mag = b_neg ? -divisor_i : divisor_i;
    quo_d = qneg_q ? -q_raw : q_raw;
    rem_d = rneg_q ? -step_rem : step_rem;
  end

  always_ff @(posedge clk_i) begin
    if (accept) begin
      qneg_q <= a_neg ^ b_neg;
      rneg_q <= a_neg;
    end
  end
`else
  logic unused_signed;

  assign unused_signed = signed_i;

  always_comb begin
    a_mag = dividend_i;
    b_mag = divisor_i;
    quo_d = q_raw;
    rem_d = step_rem;
  end
`endif

  always_ff @(posedge clk_i) begin
    if (accept) begin
      acc_q  <= a_mag;
      prem_q <= '0;
      dvs_q  <= b_mag;
    end else if (state_q == ST_CALC) begin
      acc_q  <= q_raw;
      prem_q <= step_rem;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
      quo_q   <= '0;
      rem_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            cnt_q <= '0;
            if (divisor_i == '0) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
              dz_q    <= 1'b1;
              quo_q   <= '1;
              rem_q   <= dividend_i;
            end else begin
              state_q <= ST_CALC;
              busy_q  <= 1'b1;
            end
          end
        end
        ST_CALC: begin
          if (cnt_q == CNT_LAST) begin
            state_q <= ST_DONE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            dz_q    <= 1'b0;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign quotient_o  = quo_q;
  assign remainder_o = rem_q;
  assign div_zero_o  = dz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Randomized self-checking bench for seq_divider (WIDTH=32); expectations
// follow SEQ_DIVIDER_SIGNED_EN the same way the design build does.
module tb_seq_divider;

  logic        clk = 1'b0;
  logic        rst_n_i = 1'b0;
  logic        start_i = 1'b0;
  logic        signed_i = 1'b0;
  logic [31:0] dividend_i = '0;
  logic [31:0] divisor_i = '0;
  logic        busy_o, done_o, div_zero_o;
  logic [31:0] quotient_o, remainder_o;

  int n_tests = 0;
  int n_fail  = 0;

  seq_divider #(.WIDTH(32)) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n_i),
    .start_i     (start_i),
    .signed_i    (signed_i),
    .dividend_i  (dividend_i),
    .divisor_i   (divisor_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .quotient_o  (quotient_o),
    .remainder_o (remainder_o),
    .div_zero_o  (div_zero_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer division on the operands as the spec defines them.
  function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic s,
                                output logic [31:0] q, output logic [31:0] r,
                                output logic dz);
    longint sa, sb;
    if (b == 32'd0) begin
      q = '1; r = a; dz = 1'b1;
      return;
    end
    dz = 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = 32'(sa / sb);
      r  = 32'(sa % sb);
      return;
    end
`else
    sa = longint'(s);
    sb = sa;
`endif
    q = a / b;
    r = a % b;
  endfunction

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"}, 64'(busy_o), 64'd0);
    chk({tag, "_done"}, 64'(done_o), 64'd0);
    chk({tag, "_quo"},  64'(quotient_o), 64'd0);
    chk({tag, "_rem"},  64'(remainder_o), 64'd0);
    chk({tag, "_dz"},   64'(div_zero_o), 64'd0);
  endtask

  // inj_cyc: cycle at which an extra 9/3 start is attempted (0 = none).
  // rst_cyc: cycle at which reset is pulsed, aborting the operation (0 = none).
  task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                         input string tag, input logic [31:0] eq, input logic [31:0] er,
                         input logic edz, input int inj_cyc, input int rst_cyc);
    int exp_lat, got_lat;
    bit busy_bad;
    exp_lat  = (b == 32'd0) ? 1 : 33;
    got_lat  = 0;
    busy_bad = 1'b0;
    @(negedge clk);
    start_i = 1'b1; signed_i = s; dividend_i = a; divisor_i = b;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (n == rst_cyc) begin
        rst_n_i = 1'b0;
        #1;
        check_reset_outputs({tag, "_midrst"});
        @(negedge clk);
        rst_n_i = 1'b1;
        return;
      end
      if (done_o === 1'b1) begin
        got_lat = n;
        if (busy_o !== 1'b0) busy_bad = 1'b1;
        break;
      end
      if (exp_lat > 1 && busy_o !== 1'b1) busy_bad = 1'b1;
      if (n == 1) start_i = 1'b0;
      if (n == inj_cyc) begin
        start_i = 1'b1; dividend_i = 32'd9; divisor_i = 32'd3;
      end else if (n == inj_cyc + 1) begin
        start_i = 1'b0;
      end
    end
    start_i = 1'b0;
    chk({tag, "_lat"},  64'(got_lat), 64'(exp_lat));
    chk({tag, "_quo"},  64'(quotient_o), 64'(eq));
    chk({tag, "_rem"},  64'(remainder_o), 64'(er));
    chk({tag, "_dz"},   64'(div_zero_o), 64'(edz));
    chk({tag, "_busy"}, 64'(busy_bad), 64'd0);
    @(negedge clk);
    chk({tag, "_pulse"}, 64'(done_o), 64'd0);
    chk({tag, "_hold"},  64'(quotient_o), 64'(eq));
  endtask

  initial begin
    logic [31:0] a, b, q, r;
    logic s, dz;

    #1;
    check_reset_outputs("por");
    @(negedge clk);
    rst_n_i = 1'b1;

    run_div(32'd100, 32'd7, 1'b0, "u100d7", 32'd14, 32'd2, 1'b0, 0, 0);
    run_div(32'd5, 32'd0, 1'b0, "dzero", 32'hFFFFFFFF, 32'd5, 1'b1, 0, 0);
`ifdef SEQ_DIVIDER_SIGNED_EN
    run_div(32'hFFFFFFF9, 32'd2, 1'b1, "neg7d2", 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 0, 0);
    run_div(32'h80000000, 32'hFFFFFFFF, 1'b1, "ovf", 32'h80000000, 32'd0, 1'b0, 0, 0);
`else
    run_div(32'hFFFFFFF9, 32'd2, 1'b1, "neg7d2", 32'h7FFFFFFC, 32'd1, 1'b0, 0, 0);
    run_div(32'h80000000, 32'hFFFFFFFF, 1'b1, "ovf", 32'd0, 32'h80000000, 1'b0, 0, 0);
`endif
    run_div(32'd100, 32'd7, 1'b0, "ignore", 32'd14, 32'd2, 1'b0, 5, 0);
    run_div(32'd100, 32'd7, 1'b0, "abort", 32'd0, 32'd0, 1'b0, 0, 10);
    run_div(32'd9, 32'd3, 1'b0, "afterrst", 32'd3, 32'd0, 1'b0, 0, 0);

    for (int i = 0; i < 40; i++) begin
      a = $urandom();
      case ($urandom_range(0, 3))
        0:       b = 32'($urandom_range(0, 15));
        1:       b = 32'hFFFFFFFF - 32'($urandom_range(0, 7));
        default: b = $urandom();
      endcase
      if (i % 10 == 0) b = 32'd0;
      s = 1'($urandom_range(0, 1));
      model(a, b, s, q, r, dz);
      run_div(a, b, s, $sformatf("rnd%0d", i), q, r, dz, 0, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
